// File: rtl/timer_scheduler_if.sv
// Peripheral bus bundle between the CPU and timer_scheduler (read port plus write port).
// Latency: none in the bundle itself; read_data is driven one cycle after read_addr is sampled.
// Backpressure: none; writes are single-cycle strobes and reads are always accepted.
interface timer_scheduler_if;
   logic [15:0] read_addr;
   logic [15:0] read_data;
   logic [15:0] write_addr;
   logic [15:0] write_data;
   logic        write_strobe;

   modport master (
      output read_addr,
      output write_addr,
      output write_data,
      output write_strobe,
      input  read_data
   );

   modport slave (
      input  read_addr,
      input  write_addr,
      input  write_data,
      input  write_strobe,
      output read_data
   );
endinterface

// File: rtl/timer_scheduler.sv
// Memory-mapped 4-channel alarm scheduler: shared prescaler, 16-bit reload down-counters, pending/IRQ/vector.
// Latency: 1-cycle registered read data; o_irq asserts one cycle after a pending bit sets.
// Backpressure: none; every write strobe and every read address is accepted on its clock edge.
// Optional: define TIMER_SCHED_OVERRUN_EN to add per-channel overrun bits at STATUS[7:4].
module timer_scheduler #(
   parameter logic [15:0] BASE_ADDR = 16'h8210,
   parameter int          NUM_CH    = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   timer_scheduler_if.slave  bus,
   output logic              o_irq
);

   // Channels at or above NUM_CH never accept writes, so their state stays 0 and reads back 0.
   localparam logic [3:0] CH_MASK = 4'((1 << NUM_CH) - 1);

   // Register state
   logic        gen;
   logic [7:0]  presc;
   logic [7:0]  psc_cnt;
   logic [3:0]  pending;
   logic [3:0]  en;
   logic [3:0]  per;
   logic [3:0]  ie;
   logic [15:0] reload [4];
   logic [15:0] count  [4];
   logic [15:0] rd_q;
   logic        oe_q;

   // Decode and datapath
   logic [15:0] wr_off;
   logic [15:0] rd_off;
   logic        wr_hit;
   logic        rd_hit;
   logic [3:0]  wr_idx;
   logic [3:0]  rd_idx;
   logic        wr_ctrl;
   logic        wr_stat;
   logic [3:0]  wr_rld;
   logic [3:0]  wr_chc;
   logic [3:0]  ch_wr;
   logic        tick;
   logic [3:0]  expire;
   logic [3:0]  w1c_pend;
   logic [3:0]  ovr_rd;
   logic [15:0] vec;
   logic [15:0] rd_mux;

   assign wr_off   = bus.write_addr - BASE_ADDR;
   assign rd_off   = bus.read_addr - BASE_ADDR;
   assign wr_hit   = bus.write_strobe && (wr_off < 16'd16);
   assign rd_hit   = (rd_off < 16'd16);
   assign wr_idx   = wr_off[3:0];
   assign rd_idx   = rd_off[3:0];
   assign wr_ctrl  = wr_hit && (wr_idx == 4'd0);
   assign wr_stat  = wr_hit && (wr_idx == 4'd1);
   assign w1c_pend = wr_stat ? (bus.write_data[3:0] & CH_MASK) : 4'b0;
   assign ch_wr    = wr_rld | wr_chc;

   // Tick is one cycle wide at the prescaler terminal value; a CTRL write on that same
   // edge still lets the tick land, it only restarts the prescaler afterwards.
   assign tick = gen && (psc_cnt == presc);

   // Per-channel write decode and expiry detection; a software write to a channel
   // suppresses that channel's tick update (and its expiry) for the cycle.
   always_comb begin
      wr_rld = 4'b0;
      wr_chc = 4'b0;
      expire = 4'b0;
      for (int c = 0; c < 4; c++) begin
         wr_rld[c] = wr_hit && CH_MASK[c] && (wr_idx == 4'(4 + 2 * c));
         wr_chc[c] = wr_hit && CH_MASK[c] && (wr_idx == 4'(5 + 2 * c));
      end
      for (int c = 0; c < 4; c++) begin
         expire[c] = tick && en[c] && (count[c] == 16'd0) && !ch_wr[c];
      end
   end

   // Vector: lowest-index channel that is both pending and interrupt-enabled.
   always_comb begin
      vec = 16'h0000;
      for (int c = 3; c >= 0; c--) begin
         if (pending[c] && ie[c]) begin
            vec = {1'b1, 13'b0, 2'(c)};
         end
      end
   end

   // Global control and shared prescaler.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         gen     <= 1'b0;
         presc   <= 8'h00;
         psc_cnt <= 8'h00;
      end else begin
         if (wr_ctrl) begin
            gen     <= bus.write_data[0];
            presc   <= bus.write_data[15:8];
            psc_cnt <= 8'h00;
         end else if (gen) begin
            psc_cnt <= tick ? 8'h00 : psc_cnt + 8'd1;
         end
      end
   end

   // Channel registers and down-counters; software writes win over tick updates.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en  <= 4'b0;
         per <= 4'b0;
         ie  <= 4'b0;
         for (int c = 0; c < 4; c++) begin
            reload[c] <= 16'h0000;
            count[c]  <= 16'h0000;
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (wr_rld[c]) begin
               reload[c] <= bus.write_data;
               count[c]  <= bus.write_data;
            end else if (wr_chc[c]) begin
               en[c]  <= bus.write_data[0];
               per[c] <= bus.write_data[1];
               ie[c]  <= bus.write_data[2];
               if (bus.write_data[0] && !en[c]) begin
                  count[c] <= reload[c];
               end
            end else if (tick && en[c]) begin
               if (count[c] != 16'd0) begin
                  count[c] <= count[c] - 16'd1;
               end else if (per[c]) begin
                  count[c] <= reload[c];
               end else begin
                  en[c] <= 1'b0;
               end
            end
         end
      end
   end

   // Pending bits: hardware set wins over a same-cycle write-1-to-clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending <= 4'b0;
      end else begin
         pending <= (pending & ~w1c_pend) | expire;
      end
   end

`ifdef TIMER_SCHED_OVERRUN_EN
   logic [3:0] ovr;
   logic [3:0] w1c_ovr;
   assign w1c_ovr = wr_stat ? (bus.write_data[7:4] & CH_MASK) : 4'b0;

   // Overrun: an expiry landing on an already-pending channel; set wins over clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovr <= 4'b0;
      end else begin
         ovr <= (ovr & ~w1c_ovr) | (expire & pending);
      end
   end
   assign ovr_rd = ovr;
`else
   assign ovr_rd = 4'b0;
`endif

   // Interrupt is a registered OR of enabled pending bits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_irq <= 1'b0;
      end else begin
         o_irq <= |(pending & ie);
      end
   end

   // Read mux over the 16-word window; holes and unimplemented channels read 0.
   always_comb begin
      rd_mux = 16'h0000;
      case (rd_idx)
         4'd0:    rd_mux = {presc, 7'b0, gen};
         4'd1:    rd_mux = {8'b0, ovr_rd, pending};
         4'd2:    rd_mux = vec;
         default: rd_mux = 16'h0000;
      endcase
      for (int c = 0; c < 4; c++) begin
         if (rd_idx == 4'(4 + 2 * c))  rd_mux = reload[c];
         if (rd_idx == 4'(5 + 2 * c))  rd_mux = {13'b0, ie[c], per[c], en[c]};
         if (rd_idx == 4'(12 + c))     rd_mux = count[c];
      end
   end

   // Registered read data and output enable; the bus floats when the window is not addressed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_q <= 16'h0000;
         oe_q <= 1'b0;
      end else begin
         rd_q <= rd_hit ? rd_mux : 16'h0000;
         oe_q <= rd_hit;
      end
   end

   assign bus.read_data = oe_q ? rd_q : {16{1'bz}};

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with a queued scoreboard for reads and interrupt samples.
// Latency: read results are compared the cycle after the address is presented.
// Backpressure: none; stimulus tasks each consume exactly one clock.
module tb_timer_scheduler;

   localparam logic [15:0] A_CTRL = 16'h8210;
   localparam logic [15:0] A_STAT = 16'h8211;
   localparam logic [15:0] A_VEC  = 16'h8212;
   localparam logic [15:0] A_HOLE = 16'h8213;
   localparam logic [15:0] A_RLD0 = 16'h8214;
   localparam logic [15:0] A_CHC0 = 16'h8215;
   localparam logic [15:0] A_RLD1 = 16'h8216;
   localparam logic [15:0] A_CHC1 = 16'h8217;
   localparam logic [15:0] A_RLD2 = 16'h8218;
   localparam logic [15:0] A_CHC2 = 16'h8219;
   localparam logic [15:0] A_RLD3 = 16'h821A;
   localparam logic [15:0] A_CHC3 = 16'h821B;
   localparam logic [15:0] A_CNT0 = 16'h821C;

`ifdef TIMER_SCHED_OVERRUN_EN
   localparam logic [15:0] EXP_COLL = 16'h0011;
`else
   localparam logic [15:0] EXP_COLL = 16'h0001;
`endif

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   logic o_irq;

   timer_scheduler_if bus ();

   timer_scheduler #(
      .BASE_ADDR (16'h8210),
      .NUM_CH    (4)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus),
      .o_irq   (o_irq)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [15:0] v;
      bit          hiz;
      string       nm;
   } rexp_t;

   typedef struct {
      logic  v;
      string nm;
   } iexp_t;

   rexp_t rq[$];
   iexp_t iq[$];
   rexp_t re;
   iexp_t ie_e;
   bit    ok;

   int total = 0;
   int bad   = 0;

   logic rd_req    = 1'b0;
   logic rd_req_d  = 1'b0;
   logic irq_req   = 1'b0;
   logic irq_req_d = 1'b0;

   always @(posedge i_clk) begin
      rd_req_d  <= rd_req;
      irq_req_d <= irq_req;
   end

   // Monitor: pops the oldest expectation whenever the DUT presents a result.
   always @(negedge i_clk) begin
      if (rd_req_d) begin
         total++;
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL rd_underflow: read result with no expectation, got %h", bus.read_data);
         end else begin
            re = rq.pop_front();
            if (re.hiz) ok = (bus.read_data === 16'hzzzz) || (bus.read_data === 16'h0000);
            else        ok = (bus.read_data === re.v);
            if (!ok) begin
               bad++;
               $display("FAIL %s: read_data=%h expected=%h hiz=%0d", re.nm, bus.read_data, re.v, re.hiz);
            end
         end
      end
      if (irq_req_d) begin
         total++;
         if (iq.size() == 0) begin
            bad++;
            $display("FAIL irq_underflow: irq sample with no expectation, got %b", o_irq);
         end else begin
            ie_e = iq.pop_front();
            if (o_irq !== ie_e.v) begin
               bad++;
               $display("FAIL %s: o_irq=%b expected=%b", ie_e.nm, o_irq, ie_e.v);
            end
         end
      end
   end

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus.write_addr   = a;
      bus.write_data   = d;
      bus.write_strobe = 1'b1;
      @(negedge i_clk);
      bus.write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] v, input bit hz, input string nm);
      rexp_t e;
      e.v   = v;
      e.hiz = hz;
      e.nm  = nm;
      rq.push_back(e);
      bus.read_addr = a;
      rd_req = 1'b1;
      @(negedge i_clk);
      rd_req = 1'b0;
   endtask

   task automatic chk_irq(input logic v, input string nm);
      iexp_t e;
      e.v  = v;
      e.nm = nm;
      iq.push_back(e);
      irq_req = 1'b1;
      @(negedge i_clk);
      irq_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.read_addr    = 16'h0000;
      bus.write_addr   = 16'h0000;
      bus.write_data   = 16'h0000;
      bus.write_strobe = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      // 1. Reset mid-count
      wr(A_RLD0, 16'd100);
      wr(A_CHC0, 16'h0003);
      wr(A_RLD1, 16'd0);
      wr(A_CHC1, 16'h0005);
      wr(A_CTRL, 16'h0001);
      idle(2);
      chk_irq(1'b1, "t1_irq_before_reset");
      rd(A_CNT0, 16'd97, 1'b0, "t1_count_running");
      #3 i_rst_n = 1'b0;
      #1;
      total++;
      if (o_irq !== 1'b0) begin
         bad++;
         $display("FAIL t1_irq_async: o_irq=%b expected=0", o_irq);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      rd(A_CNT0, 16'h0000, 1'b0, "t1_count_after_reset");
      rd(A_CTRL, 16'h0000, 1'b0, "t1_ctrl_after_reset");
      rd(16'h0000, 16'h0000, 1'b1, "t1_bus_hiz");
      chk_irq(1'b0, "t1_irq_after_reset");

      // 2. One-shot
      wr(A_RLD0, 16'd3);
      wr(A_CHC0, 16'h0005);
      wr(A_CTRL, 16'h0001);
      chk_irq(1'b0, "t2_irq_early");
      rd(A_STAT, 16'h0000, 1'b0, "t2_status_early");
      rd(A_CNT0, 16'd1, 1'b0, "t2_count_one");
      chk_irq(1'b0, "t2_irq_on_expiry_edge");
      chk_irq(1'b1, "t2_irq");
      rd(A_STAT, 16'h0001, 1'b0, "t2_status");
      rd(A_CHC0, 16'h0004, 1'b0, "t2_chctrl_en_cleared");
      rd(A_CNT0, 16'h0000, 1'b0, "t2_count_zero");
      idle(3);
      rd(A_CNT0, 16'h0000, 1'b0, "t2_count_stays_zero");
      wr(A_STAT, 16'h0001);
      chk_irq(1'b0, "t2_irq_cleared");

      // 3. Periodic with prescale
      wr(A_CTRL, 16'h0000);
      wr(A_RLD1, 16'd1);
      wr(A_CHC1, 16'h0007);
      wr(A_CTRL, 16'h0301);
      idle(7);
      chk_irq(1'b0, "t3_irq_before_expiry");
      chk_irq(1'b1, "t3_irq_first");
      rd(A_STAT, 16'h0002, 1'b0, "t3_status_first");
      wr(A_STAT, 16'h0002);
      chk_irq(1'b0, "t3_irq_dropped");
      idle(3);
      chk_irq(1'b0, "t3_irq_expiry_edge");
      chk_irq(1'b1, "t3_irq_second");
      rd(A_STAT, 16'h0002, 1'b0, "t3_status_second");
      rd(A_CTRL, 16'h0301, 1'b0, "t3_ctrl_readback");
      wr(A_CTRL, 16'h0000);
      wr(A_CHC1, 16'h0000);
      wr(A_STAT, 16'h00FF);

      // 4. Simultaneous expiry
      wr(A_RLD2, 16'd2);
      wr(A_CHC2, 16'h0005);
      wr(A_RLD3, 16'd2);
      wr(A_CHC3, 16'h0005);
      wr(A_CTRL, 16'h0001);
      idle(3);
      rd(A_STAT, 16'h000C, 1'b0, "t4_status_both");
      rd(A_VEC, 16'h8002, 1'b0, "t4_vector_ch2");
      wr(A_STAT, 16'h0004);
      rd(A_VEC, 16'h8003, 1'b0, "t4_vector_ch3");
      wr(A_STAT, 16'h0008);
      rd(A_VEC, 16'h0000, 1'b0, "t4_vector_none");
      chk_irq(1'b0, "t4_irq_none");

      // 5. Collision of W1C and expiry
      wr(A_RLD0, 16'd0);
      wr(A_CHC0, 16'h0007);
      idle(1);
      wr(A_STAT, 16'h0011);
      rd(A_STAT, EXP_COLL, 1'b0, "t5_status_set_wins");
      chk_irq(1'b1, "t5_irq");
      wr(A_CHC0, 16'h0000);
      wr(A_CTRL, 16'h0000);
      wr(A_STAT, 16'h00FF);
      rd(A_STAT, 16'h0000, 1'b0, "t5_status_cleared");

      // 6. Freeze and resume
      wr(A_RLD0, 16'd9);
      wr(A_CHC0, 16'h0001);
      wr(A_CTRL, 16'h0001);
      idle(3);
      wr(A_CTRL, 16'h0000);
      rd(A_CNT0, 16'd5, 1'b0, "t6_count_frozen");
      idle(20);
      rd(A_CNT0, 16'd5, 1'b0, "t6_count_still_frozen");
      wr(A_CTRL, 16'h0001);
      rd(A_CNT0, 16'd5, 1'b0, "t6_count_before_first_tick");
      rd(A_CNT0, 16'd4, 1'b0, "t6_count_resumed");
      rd(A_RLD0, 16'd9, 1'b0, "t6_reload_readback");
      rd(A_HOLE, 16'h0000, 1'b0, "t6_unmapped_offset");
      wr(A_VEC, 16'hFFFF);
      rd(A_VEC, 16'h0000, 1'b0, "t6_vector_readonly");
      rd(16'h8220, 16'h0000, 1'b1, "t6_out_of_window_hiz");

      idle(2);
      total++;
      if (rq.size() != 0 || iq.size() != 0) begin
         bad++;
         $display("FAIL drain: leftover rd=%0d irq=%0d expected 0", rq.size(), iq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
